// File: rtl/mem_wb_stage_pkg.sv
// Shared ARM pipeline definitions: default path widths, the PC register index,
// and the write-back source encoding.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_W_DEF  = 4;
    localparam int PC_IDX     = 15;

    typedef enum logic {
        WB_SEL_ALU = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

endpackage

// File: rtl/mem_wb_stage_wb_mux.sv
// Write-back source select: returns load data for loads and the ALU result
// for everything else.
module wb_mux
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] value
);

    wb_sel_e sel_e;

    always_comb begin
        sel_e = wb_sel_e'(sel);
        value = (sel_e == WB_SEL_MEM) ? mem_data : alu_result;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with freeze/flush control, write-back select and a
// retired-instruction counter.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic              wb_en_in,
    input  logic              mem_read_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              freeze,
    input  logic              flush,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_dest,
    output logic [DATA_W-1:0] wb_value,
    output logic              pc_write,
    output logic [31:0]       retired
);

    logic              valid_q;
    logic              wb_en_q;
    logic              mem_read_q;
    logic [DATA_W-1:0] alu_result_q;
    logic [DATA_W-1:0] mem_data_q;
    logic [REG_W-1:0]  dest_q;
    logic [31:0]       retired_q;

    // Flush wins over freeze; a bubble (valid_in = 0) still captures its data
    // fields so the registers stay deterministic, but valid_q gates any write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else if (flush) begin
            valid_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            dest_q       <= '0;
        end else if (!freeze) begin
            valid_q      <= valid_in;
            wb_en_q      <= wb_en_in;
            mem_read_q   <= mem_read_in;
            alu_result_q <= alu_result_in;
            mem_data_q   <= mem_data_in;
            dest_q       <= dest_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (valid_in && !freeze && !flush) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    wb_mux #(
        .DATA_W(DATA_W)
    ) u_wb_mux (
        .sel        (mem_read_q),
        .alu_result (alu_result_q),
        .mem_data   (mem_data_q),
        .value      (wb_value)
    );

    assign wb_en    = valid_q & wb_en_q;
    assign wb_dest  = dest_q;
    assign pc_write = wb_en & (dest_q == REG_W'(PC_IDX));
    assign retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: load/ALU write-back, freeze, flush, bubbles,
// counter wrap and asynchronous reset.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic        wb_en_in;
    logic        mem_read_in;
    logic [31:0] alu_result_in;
    logic [31:0] mem_data_in;
    logic [3:0]  dest_in;
    logic        freeze;
    logic        flush;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        pc_write;
    logic [31:0] retired;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .wb_en_in      (wb_en_in),
        .mem_read_in   (mem_read_in),
        .alu_result_in (alu_result_in),
        .mem_data_in   (mem_data_in),
        .dest_in       (dest_in),
        .freeze        (freeze),
        .flush         (flush),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value),
        .pc_write      (pc_write),
        .retired       (retired)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic we, input logic mr,
                         input logic [31:0] alu, input logic [31:0] md, input logic [3:0] d);
        valid_in      = v;
        wb_en_in      = we;
        mem_read_in   = mr;
        alu_result_in = alu;
        mem_data_in   = md;
        dest_in       = d;
    endtask

    initial begin
        rst    = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #12;
        check("rst_wb_en",    {31'b0, wb_en},    32'd0);
        check("rst_pc_write", {31'b0, pc_write}, 32'd0);
        check("rst_wb_dest",  {28'b0, wb_dest},  32'd0);
        check("rst_wb_value", wb_value,          32'd0);
        check("rst_retired",  retired,           32'd0);

        @(negedge clk);
        rst = 1'b1;

        // Load, first capture after reset release
        drive(1'b1, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'd3);
        step();
        check("load_wb_en",    {31'b0, wb_en},    32'd1);
        check("load_wb_dest",  {28'b0, wb_dest},  32'd3);
        check("load_wb_value", wb_value,          32'hDEADBEEF);
        check("load_pc_write", {31'b0, pc_write}, 32'd0);
        check("load_retired",  retired,           32'd1);

        // ALU op to R15, back-to-back
        drive(1'b1, 1'b1, 1'b0, 32'h12345678, 32'hCAFEF00D, 4'd15);
        step();
        check("alu_wb_value", wb_value,          32'h12345678);
        check("alu_pc_write", {31'b0, pc_write}, 32'd1);
        check("alu_retired",  retired,           32'd2);

        // Instruction A, then freeze for 3 cycles with changing inputs
        drive(1'b1, 1'b1, 1'b0, 32'h0000A5A5, 32'h0, 4'd5);
        step();
        check("a_wb_value", wb_value, 32'h0000A5A5);
        check("a_retired",  retired,  32'd3);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h1111 + i, 32'h2222 + i, 4'd7);
            step();
            check("frz_wb_value", wb_value,         32'h0000A5A5);
            check("frz_wb_dest",  {28'b0, wb_dest}, 32'd5);
            check("frz_wb_en",    {31'b0, wb_en},   32'd1);
            check("frz_retired",  retired,          32'd3);
        end

        // Flush overrides freeze
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h9, 32'h9, 4'd15);
        step();
        check("flush_wb_en",    {31'b0, wb_en},    32'd0);
        check("flush_pc_write", {31'b0, pc_write}, 32'd0);
        check("flush_wb_value", wb_value,          32'd0);
        check("flush_wb_dest",  {28'b0, wb_dest},  32'd0);
        check("flush_retired",  retired,           32'd3);
        flush  = 1'b0;
        freeze = 1'b0;

        // Bubble with wb_en_in high must not write
        drive(1'b0, 1'b1, 1'b0, 32'h77, 32'h0, 4'd15);
        step();
        check("bubble_wb_en",    {31'b0, wb_en},    32'd0);
        check("bubble_pc_write", {31'b0, pc_write}, 32'd0);
        check("bubble_retired",  retired,           32'd3);

        // Load selected but not written
        drive(1'b1, 1'b0, 1'b1, 32'h66, 32'h55, 4'd2);
        step();
        check("nowr_wb_en",    {31'b0, wb_en}, 32'd0);
        check("nowr_wb_value", wb_value,       32'h55);
        check("nowr_retired",  retired,        32'd4);

        // Counter wrap
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        @(negedge clk);
        force dut.retired_q = 32'hFFFFFFFF;
        #1;
        release dut.retired_q;
        #1;
        check("wrap_preload", retired, 32'hFFFFFFFF);
        drive(1'b1, 1'b1, 1'b0, 32'h1, 32'h0, 4'd1);
        step();
        check("wrap_retired", retired, 32'd0);

        // Asynchronous reset mid-cycle with a write pending
        drive(1'b1, 1'b1, 1'b0, 32'hABCD, 32'h0, 4'd15);
        step();
        check("pre_rst_wb_en", {31'b0, wb_en}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_wb_en",    {31'b0, wb_en},    32'd0);
        check("arst_pc_write", {31'b0, pc_write}, 32'd0);
        check("arst_retired",  retired,           32'd0);
        check("arst_wb_value", wb_value,          32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 32'h0, 32'h13579BDF, 4'd4);
        step();
        check("post_rst_wb_value", wb_value, 32'h13579BDF);
        check("post_rst_retired",  retired,  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of data and result paths.
REQ-002 SHALL have parameter REG_W, default 4: width of the register-file index.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1: MEM stage holds a real instruction this cycle.
REQ-006 SHALL have port wb_en_in, input, 1: instruction writes the register file.
REQ-007 SHALL have port mem_read_in, input, 1: instruction is a load, so write-back takes memory data.
REQ-008 SHALL have port alu_result_in, input, DATA_W: ALU result / effective address forwarded through MEM.
REQ-009 SHALL have port mem_data_in, input, DATA_W: combinational read result from the MEM stage.
REQ-010 SHALL have port dest_in, input, REG_W: destination register index.
REQ-011 SHALL have port freeze, input, 1: hazard-unit stall; hold stage contents.
REQ-012 SHALL have port flush, input, 1: squash; capture a bubble.
REQ-013 SHALL have port wb_en, output, 1: register-file write enable (valid_r & wb_en_r).
REQ-014 SHALL have port wb_dest, output, REG_W: register-file write index.
REQ-015 SHALL have port wb_value, output, DATA_W: register-file write data.
REQ-016 SHALL have port pc_write, output, 1: wb_en asserted with wb_dest == all-ones (R15).
REQ-017 SHALL have port retired, output, 32: count of instructions captured into the stage.

Function
REQ-018 SHALL register valid, wb_en, mem_read, alu_result, mem_data and dest on posedge clk; latency from the MEM inputs to the outputs is exactly 1 cycle.
REQ-019 SHALL drive wb_value = mem_data_r when mem_read_r = 1, otherwise alu_result_r, combinationally from the registers.
REQ-020 SHALL, when freeze = 1 and flush = 0, hold all registers unchanged; outputs stay stable.
REQ-021 SHALL, when flush = 1, load valid_r = 0, wb_en_r = 0, mem_read_r = 0 and zero the data/dest registers; flush overrides freeze.
REQ-022 SHALL, when valid_in = 0 with no freeze or flush, capture a bubble: valid_r = 0 and wb_en = 0, with data registers don't-care but deterministic.
REQ-023 SHALL gate wb_en and pc_write with valid_r; no register-file write occurs from a bubble, even if wb_en_in was high.
REQ-024 SHALL increment retired by 1 on each posedge where valid_in = 1, freeze = 0 and flush = 0; wraps from 0xFFFFFFFF to 0.
REQ-025 SHALL treat mem_read_in with wb_en_in = 0 as legal; the value is selected but not written.
REQ-026 SHALL apply back-to-back instructions on consecutive cycles with no bubble insertion by the stage itself.

Reset
REQ-027 SHALL, while rst = 0, asynchronously clear every register: valid_r = 0, wb_en = 0, pc_write = 0, wb_dest = 0, wb_value = 0, retired = 0.
REQ-028 SHALL accept capture on the first posedge after rst deasserts; reset asserted mid-pipeline discards the in-flight instruction.

Structure
REQ-029 SHALL take DATA_W and REG_W defaults and the PC index constant (15) from the shared ARM definitions package/header.
REQ-030 SHALL implement the write-back select as one sub-module, wb_mux (2:1, DATA_W wide); the pipeline register and counter stay inline.

Verification
REQ-031 Load: valid_in = 1, wb_en_in = 1, mem_read_in = 1, mem_data_in = 0xDEADBEEF, alu_result_in = 0x40, dest_in = 3 -> next cycle wb_en = 1, wb_dest = 3, wb_value = 0xDEADBEEF, retired = 1.
REQ-032 ALU op: mem_read_in = 0, alu_result_in = 0x12345678, dest_in = 15 -> wb_value = 0x12345678, pc_write = 1.
REQ-033 Freeze: capture instruction A, then freeze = 1 for 3 cycles with new inputs -> outputs stay A for 3 cycles and retired is unchanged.
REQ-034 Flush + freeze: both = 1 with valid_in = 1 -> next cycle wb_en = 0, pc_write = 0, retired unchanged.
REQ-035 Counter wrap: force retired to 0xFFFFFFFF, capture one valid instruction -> retired = 0.
REQ-036 Async reset: drop rst mid-cycle with wb_en = 1 -> wb_en = 0 and retired = 0 immediately, without waiting for clk.
